sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
- Parametrised time-multiplexed seven-segment scan controller; successor to the fixed 4-digit game display.
- Single clock, with internal refresh and blink prescalers; there are no external divided clocks.
- Supports N digits, a tear-free double-buffered value load with a valid/ready handshake, and four display modes: blank, steady, finite/infinite blink, and YES/NO message.
- Sits between the game FSM and board anode/segment pins.

Parameters:
- NUM_DIGITS, 4: digit count; legal range 3..8.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be >= 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be >= 1.
- BLINK_COUNT, 3: number of off-phases before blinking stops; 0 means blink forever.

Ports:
- clk, input, 1: sole clock; all logic is on its rising edge.
- rstN, input, 1: synchronous, active-low reset.
- mode, input, 2: 00 blank, 01 steady, 10 blink, 11 message.
- passFail, input, 1: in message mode, 1 shows YES and 0 shows NO.
- value, input, 4*NUM_DIGITS: glyph codes; nibble [4*NUM_DIGITS-1 -: 4] is digit 0 (leftmost).
- valueValid, input, 1: load request.
- valueReady, output, 1: high when no load is pending.
- anodeActivate, output, NUM_DIGITS: active-low anode enables; bit NUM_DIGITS-1 is digit 0.
- LED_out, output, 7: active-low segments, ordered {g,f,e,d,c,b,a}.
- blinkDone, output, 1: one-cycle pulse when a finite blink sequence ends.

Behaviour:
- Reset (rstN=0 at an edge), with priority over everything:
  - prescaler=0, digit index=0, shadow and display registers=0, pending=0.
  - blink phase=visible, frame and off-phase counters=0.
  - anodeActivate=all 1, LED_out=7'h7F, valueReady=1, blinkDone=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick=1 in the cycle it equals REFRESH_DIV-1.
  - On each tick, the index advances by 1 modulo NUM_DIGITS.
  - frameEnd = tick AND index==NUM_DIGITS-1.
- Outputs are registered from the index and state: one cycle of latency after the index changes.
  - Exactly one anode bit is low, or none when the digit is blanked.
- Load handshake:
  - Accept when valueValid & valueReady; write shadow and set pending; valueReady = ~pending.
  - At frameEnd with pending: copy shadow to display and clear pending.
  - Acceptance in the same cycle as frameEnd: value goes directly to display and pending stays 0 (bypass).
  - valueValid while not ready is ignored; the requester must hold it.
- Glyph decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A(Y)=0010001, B(E)=0000110, C(S)=0010010, D(N)=1001000, E(O)=1000000.
  - F=blank: the anode for that digit stays high and LED_out=7'h7F.
- Modes:
  - 00: all anodes high, LED_out=7'h7F.
  - 01: display register is shown steadily.
  - 10: display register is shown while the blink phase is visible; all anodes are high while off.
  - 11: digits 0,1,2 show Y,E,S when passFail=1, or digits 0,1 show N,O when passFail=0; all other digits are blanked. The display register is ignored but still loads.
- Blink engine (active only in mode 10):
  - The frame counter increments on frameEnd. When it reaches BLINK_FRAMES-1 at a frameEnd, it clears and the phase toggles.
  - The off-phase counter increments on each off→visible toggle.
  - BLINK_COUNT≠0 and the counter reaches BLINK_COUNT: phase stays visible, the engine halts, and blinkDone pulses in that cycle.
  - While halted the display is steady; the engine re-arms only on a mode change.
- Any change of mode:
  - Clears the blink phase to visible and clears both blink counters in the cycle after the change.
  - Does not reset the index, prescaler, or pending load.
- Mid-operation reset drops any pending load; the display returns to 0 on the next cycle.

Test Plan:
- Scan/steady, with NUM_DIGITS=4, REFRESH_DIV=4, mode=01, value=16'h1234 loaded:
  - After the next frameEnd, anodes rotate 0111→1011→1101→1110 every 4 cycles.
  - LED_out=1111001, 0100100, 0110000, 0011001 respectively.
- Tear-free load:
  - Accept 16'h5678 mid-frame → valueReady=0 until frameEnd.
  - The digits show 1234 for the rest of that frame and 5678 from the next digit-0 slot; valueReady=1 after frameEnd.
- Bypass and backpressure:
  - valueValid on the frameEnd cycle → display updates with valueReady staying 1.
  - A second valueValid while pending → ignored; shadow keeps the first value.
- Finite blink, with BLINK_FRAMES=2, BLINK_COUNT=2, frame=16 cycles, mode=10:
  - Sequence is visible 32 cycles, off 32, visible 32, off 32, then visible steady.
  - blinkDone is a single-cycle pulse at the second off→visible edge; no further toggles.
- Message, mode=11:
  - passFail=1 → digits 0..2 show 0010001, 0000110, 0010010; digit 3's anode stays high.
  - passFail=0 → only digits 0,1 are driven, with 1001000, 1000000.
- Reset and blanking:
  - rstN=0 for 1 cycle mid-blink with a load pending → next cycle all anodes=1, LED_out=7F, valueReady=1.
  - A nibble of F in mode 01 → that digit's anode is never low.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// Load channel of the seven-segment scan controller.
// Carries the glyph word and its valid/ready handshake.
//   value      : 4*NUM_DIGITS glyph codes, digit 0 in the top nibble
//   valueValid : requester has a word to load
//   valueReady : controller has no load pending
interface sevenseg_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 4
) ();

   logic [4*NUM_DIGITS-1:0] value;
   logic                    valueValid;
   logic                    valueReady;

   modport master (
      output value,
      output valueValid,
      input  valueReady
   );

   modport slave (
      input  value,
      input  valueValid,
      output valueReady
   );

endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a tear-free
// double-buffered load, blank/steady/blink/message modes and a blink engine.
// Ports:
//   clk           : sole clock, rising edge
//   rstN          : synchronous active-low reset
//   mode          : 00 blank, 01 steady, 10 blink, 11 message
//   passFail      : message mode selects YES (1) or NO (0)
//   load_if       : value / valueValid / valueReady load channel (slave)
//   anodeActivate : active-low anode enables, bit NUM_DIGITS-1 is digit 0
//   LED_out       : active-low segments {g,f,e,d,c,b,a}
//   blinkDone     : one-cycle pulse when a finite blink sequence ends
module sevenseg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter int unsigned BLINK_COUNT  = 3
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [1:0]            mode,
   input  logic                  passFail,
   sevenseg_scan_ctrl_if.slave   load_if,
   output logic [NUM_DIGITS-1:0] anodeActivate,
   output logic [6:0]            LED_out,
   output logic                  blinkDone
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned FRM_W = $clog2(BLINK_FRAMES) + 1;
   localparam int unsigned OFF_W = $clog2(BLINK_COUNT + 1) + 1;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      MODE_BLANK  = 2'b00,
      MODE_STEADY = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_MSG    = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      BLK_VISIBLE = 2'b00,
      BLK_OFF     = 2'b01,
      BLK_HALTED  = 2'b10
   } blink_state_t;

   // Active-low segment decode; F is handled as blank by the caller.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0010001;
         4'hB:    seg = 7'b0000110;
         4'hC:    seg = 7'b0010010;
         4'hD:    seg = 7'b1001000;
         4'hE:    seg = 7'b1000000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   logic [PRE_W-1:0]      prescaler_q, prescaler_d;
   logic [IDX_W-1:0]      index_q, index_d;
   logic [VAL_W-1:0]      shadow_q, shadow_d;
   logic [VAL_W-1:0]      display_q, display_d;
   logic                  pending_q, pending_d;
   logic                  value_ready_q, value_ready_d;
   logic [1:0]            mode_q;
   blink_state_t          blink_state_q, blink_state_d;
   logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic [OFF_W-1:0]      off_cnt_q, off_cnt_d;
   logic                  blink_done_q, blink_done_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [6:0]            led_q, led_d;

   logic tick_c;
   logic frame_end_c;
   logic accept_c;
   logic mode_changed_c;

   // Refresh prescaler, digit index and frame boundary.
   always_comb begin
      tick_c      = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
      frame_end_c = tick_c && (index_q == IDX_W'(NUM_DIGITS - 1));
      prescaler_d = tick_c ? '0 : prescaler_q + PRE_W'(1);
      index_d     = index_q;
      if (tick_c) begin
         index_d = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
      end
   end

   // Double-buffered load: display only changes at a frame boundary.
   always_comb begin
      accept_c      = load_if.valueValid && value_ready_q;
      shadow_d      = shadow_q;
      display_d     = display_q;
      pending_d     = pending_q;
      if (accept_c) begin
         shadow_d = load_if.value;
      end
      if (accept_c && frame_end_c) begin
         // Boundary coincides with acceptance: skip the shadow stage.
         display_d = load_if.value;
         pending_d = 1'b0;
      end else if (frame_end_c && pending_q) begin
         display_d = shadow_q;
         pending_d = 1'b0;
      end else if (accept_c) begin
         pending_d = 1'b1;
      end
      value_ready_d = ~pending_d;
   end

   // Blink engine next-state; any mode change re-arms it.
   always_comb begin
      mode_changed_c = (mode != mode_q);
      blink_state_d  = blink_state_q;
      frame_cnt_d    = frame_cnt_q;
      off_cnt_d      = off_cnt_q;
      blink_done_d   = 1'b0;
      if (mode_changed_c) begin
         blink_state_d = BLK_VISIBLE;
         frame_cnt_d   = '0;
         off_cnt_d     = '0;
      end else if ((mode_t'(mode) == MODE_BLINK) && frame_end_c) begin
         case (blink_state_q)
            BLK_VISIBLE, BLK_OFF: begin
               if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                  frame_cnt_d = '0;
                  if (blink_state_q == BLK_VISIBLE) begin
                     blink_state_d = BLK_OFF;
                  end else begin
                     off_cnt_d = off_cnt_q + OFF_W'(1);
                     if ((BLINK_COUNT != 0) && (off_cnt_d == OFF_W'(BLINK_COUNT))) begin
                        blink_state_d = BLK_HALTED;
                        blink_done_d  = 1'b1;
                     end else begin
                        blink_state_d = BLK_VISIBLE;
                     end
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + FRM_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from the current index; registered below.
   always_comb begin
      logic [3:0]            disp_code;
      logic [3:0]            msg_code;
      logic [3:0]            code;
      logic [NUM_DIGITS-1:0] onehot;
      logic                  show;

      disp_code = 4'hF;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index_q == IDX_W'(i)) begin
            disp_code                = display_q[VAL_W-1-4*i -: 4];
            onehot[NUM_DIGITS-1-i]   = 1'b1;
         end
      end

      // YES uses codes A,B,C on digits 0..2; NO uses D,E on digits 0..1.
      msg_code = 4'hF;
      if (index_q == IDX_W'(0)) begin
         msg_code = passFail ? 4'hA : 4'hD;
      end else if (index_q == IDX_W'(1)) begin
         msg_code = passFail ? 4'hB : 4'hE;
      end else if ((index_q == IDX_W'(2)) && passFail) begin
         msg_code = 4'hC;
      end

      show = 1'b1;
      code = disp_code;
      case (mode_t'(mode))
         MODE_BLANK:  show = 1'b0;
         MODE_STEADY: code = disp_code;
         MODE_BLINK:  show = (blink_state_q != BLK_OFF);
         MODE_MSG:    code = msg_code;
         default:     show = 1'b0;
      endcase

      if (!show || (code == 4'hF)) begin
         anode_d = '1;
         led_d   = SEG_BLANK;
      end else begin
         anode_d = ~onehot;
         led_d   = seg_decode(code);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         prescaler_q   <= '0;
         index_q       <= '0;
         shadow_q      <= '0;
         display_q     <= '0;
         pending_q     <= 1'b0;
         value_ready_q <= 1'b1;
         mode_q        <= 2'b00;
         blink_state_q <= BLK_VISIBLE;
         frame_cnt_q   <= '0;
         off_cnt_q     <= '0;
         blink_done_q  <= 1'b0;
         anode_q       <= '1;
         led_q         <= SEG_BLANK;
      end else begin
         prescaler_q   <= prescaler_d;
         index_q       <= index_d;
         shadow_q      <= shadow_d;
         display_q     <= display_d;
         pending_q     <= pending_d;
         value_ready_q <= value_ready_d;
         mode_q        <= mode;
         blink_state_q <= blink_state_d;
         frame_cnt_q   <= frame_cnt_d;
         off_cnt_q     <= off_cnt_d;
         blink_done_q  <= blink_done_d;
         anode_q       <= anode_d;
         led_q         <= led_d;
      end
   end

   assign load_if.valueReady = value_ready_q;
   assign anodeActivate      = anode_q;
   assign LED_out            = led_q;
   assign blinkDone          = blink_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl (4 digits, 4-cycle slots,
// 2-frame blink half-period, 2 off-phases). Expected outputs are queued
// with the cycle index (edges since reset release) at which they must
// appear; a monitor samples on the falling edge and compares.
`timescale 1ns/1ps
module tb_sevenseg_scan_ctrl;

   logic       clk;
   logic       rstN;
   logic [1:0] mode;
   logic       passFail;
   logic [3:0] anodeActivate;
   logic [6:0] LED_out;
   logic       blinkDone;

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(4)) lif ();

   sevenseg_scan_ctrl #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .BLINK_FRAMES(2),
      .BLINK_COUNT (2)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .mode         (mode),
      .passFail     (passFail),
      .load_if      (lif),
      .anodeActivate(anodeActivate),
      .LED_out      (LED_out),
      .blinkDone    (blinkDone)
   );

   typedef struct {
      int         k;
      logic [3:0] an;
      logic [6:0] led;
      logic       rdy;
      logic       done;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = -2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge count since reset release; -1 on reset edges.
   always @(posedge clk) begin
      if (!rstN) cyc <= -1;
      else       cyc <= cyc + 1;
   end

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].k == cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if ({anodeActivate, LED_out, lif.valueReady, blinkDone} !==
             {e.an, e.led, e.rdy, e.done}) begin
            errors++;
            $display("FAIL %s k=%0d: got an=%b led=%b rdy=%b done=%b, expected an=%b led=%b rdy=%b done=%b",
                     e.name, e.k, anodeActivate, LED_out, lif.valueReady, blinkDone,
                     e.an, e.led, e.rdy, e.done);
         end
      end
   end

   task automatic expect_at(input int k, input logic [3:0] an, input logic [6:0] led,
                            input logic rdy, input logic done, input string name);
      exp_t e;
      e.k = k; e.an = an; e.led = led; e.rdy = rdy; e.done = done; e.name = name;
      exp_q.push_back(e);
   endtask

   // Advance to 1ns after the edge that makes cyc == k.
   task automatic wait_cyc(input int k);
      int budget;
      budget = 2000;
      while (cyc != k && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      if (cyc != k) begin
         checks++;
         errors++;
         $display("FAIL wait_cyc: got cyc=%0d, expected %0d", cyc, k);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstN           = 1'b0;
      mode           = 2'b01;
      passFail       = 1'b0;
      lif.value      = '0;
      lif.valueValid = 1'b0;

      expect_at(-1, 4'hF, 7'h7F, 1'b1, 1'b0, "reset");
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;

      // Steady scan of 1234, loaded through the shadow at the first frame end.
      expect_at(1,  4'h7, 7'h40, 1'b0, 1'b0, "pre_load_d0");
      expect_at(5,  4'hB, 7'h40, 1'b0, 1'b0, "pre_load_d1");
      expect_at(15, 4'hE, 7'h40, 1'b1, 1'b0, "first_frame_end");
      expect_at(16, 4'h7, 7'h79, 1'b1, 1'b0, "scan_d0");
      expect_at(19, 4'h7, 7'h79, 1'b1, 1'b0, "scan_d0_hold");
      expect_at(20, 4'hB, 7'h24, 1'b1, 1'b0, "scan_d1");
      expect_at(24, 4'hD, 7'h30, 1'b1, 1'b0, "scan_d2");
      expect_at(28, 4'hE, 7'h19, 1'b1, 1'b0, "scan_d3");
      wait_cyc(0);
      lif.value = 16'h1234; lif.valueValid = 1'b1;
      wait_cyc(1);
      lif.valueValid = 1'b0;

      // Tear-free load of 5678 accepted mid-frame.
      expect_at(36, 4'hB, 7'h24, 1'b0, 1'b0, "tear_d1_old");
      expect_at(40, 4'hD, 7'h30, 1'b0, 1'b0, "tear_d2_old");
      expect_at(44, 4'hE, 7'h19, 1'b0, 1'b0, "tear_d3_old");
      expect_at(46, 4'hE, 7'h19, 1'b0, 1'b0, "tear_pending");
      expect_at(47, 4'hE, 7'h19, 1'b1, 1'b0, "tear_ready_back");
      expect_at(48, 4'h7, 7'h12, 1'b1, 1'b0, "tear_d0_new");
      expect_at(52, 4'hB, 7'h02, 1'b1, 1'b0, "tear_d1_new");
      expect_at(56, 4'hD, 7'h78, 1'b1, 1'b0, "tear_d2_new");
      expect_at(60, 4'hE, 7'h00, 1'b1, 1'b0, "tear_d3_new");
      wait_cyc(35);
      lif.value = 16'h5678; lif.valueValid = 1'b1;
      wait_cyc(36);
      lif.valueValid = 1'b0;

      // Backpressure: 3456 offered while 9012 is pending must be ignored.
      expect_at(67, 4'h7, 7'h12, 1'b0, 1'b0, "bp_pending");
      expect_at(79, 4'hE, 7'h00, 1'b1, 1'b0, "bp_ready_back");
      expect_at(80, 4'h7, 7'h10, 1'b1, 1'b0, "bp_d0");
      expect_at(84, 4'hB, 7'h40, 1'b1, 1'b0, "bp_d1");
      expect_at(88, 4'hD, 7'h79, 1'b1, 1'b0, "bp_d2");
      expect_at(92, 4'hE, 7'h24, 1'b1, 1'b0, "bp_d3");
      wait_cyc(65);
      lif.value = 16'h9012; lif.valueValid = 1'b1;
      wait_cyc(66);
      lif.value = 16'h3456;
      wait_cyc(70);
      lif.valueValid = 1'b0;

      // Bypass: 4321 offered on the frame-end cycle.
      expect_at(95,  4'hE, 7'h24, 1'b1, 1'b0, "byp_ready_kept");
      expect_at(96,  4'h7, 7'h19, 1'b1, 1'b0, "byp_d0");
      expect_at(100, 4'hB, 7'h30, 1'b1, 1'b0, "byp_d1");
      expect_at(104, 4'hD, 7'h24, 1'b1, 1'b0, "byp_d2");
      expect_at(108, 4'hE, 7'h79, 1'b1, 1'b0, "byp_d3");
      wait_cyc(94);
      lif.value = 16'h4321; lif.valueValid = 1'b1;
      wait_cyc(95);
      lif.valueValid = 1'b0;

      // Blank nibbles: 1F3F keeps digits 1 and 3 dark.
      expect_at(112, 4'h7, 7'h79, 1'b1, 1'b0, "blank_d0");
      expect_at(116, 4'hF, 7'h7F, 1'b1, 1'b0, "blank_d1");
      expect_at(119, 4'hF, 7'h7F, 1'b1, 1'b0, "blank_d1_end");
      expect_at(120, 4'hD, 7'h30, 1'b1, 1'b0, "blank_d2");
      expect_at(124, 4'hF, 7'h7F, 1'b1, 1'b0, "blank_d3");
      expect_at(127, 4'hF, 7'h7F, 1'b1, 1'b0, "blank_d3_end");
      wait_cyc(110);
      lif.value = 16'h1F3F; lif.valueValid = 1'b1;
      wait_cyc(111);
      lif.valueValid = 1'b0;

      // Message mode: YES then NO.
      expect_at(128, 4'h7, 7'h11, 1'b1, 1'b0, "yes_Y");
      expect_at(132, 4'hB, 7'h06, 1'b1, 1'b0, "yes_E");
      expect_at(136, 4'hD, 7'h12, 1'b1, 1'b0, "yes_S");
      expect_at(140, 4'hF, 7'h7F, 1'b1, 1'b0, "yes_d3_blank");
      expect_at(144, 4'h7, 7'h48, 1'b1, 1'b0, "no_N");
      expect_at(148, 4'hB, 7'h40, 1'b1, 1'b0, "no_O");
      expect_at(152, 4'hF, 7'h7F, 1'b1, 1'b0, "no_d2_blank");
      expect_at(156, 4'hF, 7'h7F, 1'b1, 1'b0, "no_d3_blank");
      wait_cyc(127);
      mode = 2'b11; passFail = 1'b1;
      wait_cyc(143);
      passFail = 1'b0;

      // Finite blink of 8888: vis 32, off 32, vis 32, off 32, then steady.
      expect_at(160, 4'h7, 7'h00, 1'b1, 1'b0, "blk_vis1_start");
      expect_at(191, 4'hE, 7'h00, 1'b1, 1'b0, "blk_vis1_end");
      expect_at(192, 4'hF, 7'h7F, 1'b1, 1'b0, "blk_off1_start");
      expect_at(223, 4'hF, 7'h7F, 1'b1, 1'b0, "blk_off1_end");
      expect_at(224, 4'h7, 7'h00, 1'b1, 1'b0, "blk_vis2_start");
      expect_at(255, 4'hE, 7'h00, 1'b1, 1'b0, "blk_vis2_end");
      expect_at(256, 4'hF, 7'h7F, 1'b1, 1'b0, "blk_off2_start");
      expect_at(286, 4'hF, 7'h7F, 1'b1, 1'b0, "blk_no_early_done");
      expect_at(287, 4'hF, 7'h7F, 1'b1, 1'b1, "blk_done_pulse");
      expect_at(288, 4'h7, 7'h00, 1'b1, 1'b0, "blk_done_cleared");
      expect_at(320, 4'h7, 7'h00, 1'b1, 1'b0, "blk_halted_a");
      expect_at(352, 4'h7, 7'h00, 1'b1, 1'b0, "blk_halted_b");
      wait_cyc(158);
      lif.value = 16'h8888; lif.valueValid = 1'b1;
      wait_cyc(159);
      lif.valueValid = 1'b0;
      mode = 2'b10;

      // Re-arm via mode change, then reset mid-blink with a load pending.
      expect_at(383, 4'hE, 7'h00, 1'b1, 1'b0, "rearm_vis");
      expect_at(384, 4'hF, 7'h7F, 1'b1, 1'b0, "rearm_off");
      expect_at(386, 4'hF, 7'h7F, 1'b0, 1'b0, "rst_pending");
      expect_at(388, 4'hF, 7'h7F, 1'b0, 1'b0, "rst_pending_off");
      expect_at(-1,  4'hF, 7'h7F, 1'b1, 1'b0, "mid_reset");
      expect_at(0,   4'h7, 7'h40, 1'b1, 1'b0, "post_rst_zero");
      expect_at(15,  4'hE, 7'h40, 1'b1, 1'b0, "post_rst_no_load");
      expect_at(16,  4'h7, 7'h40, 1'b1, 1'b0, "post_rst_dropped");
      wait_cyc(359);
      mode = 2'b01;
      wait_cyc(360);
      mode = 2'b10;
      wait_cyc(385);
      lif.value = 16'h7777; lif.valueValid = 1'b1;
      wait_cyc(386);
      lif.valueValid = 1'b0;
      wait_cyc(389);
      rstN = 1'b0;
      @(posedge clk);
      #1 rstN = 1'b1;
      wait_cyc(20);

      @(negedge clk);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s k=%0d: got never sampled, expected an=%b led=%b rdy=%b done=%b",
                  e.name, e.k, e.an, e.led, e.rdy, e.done);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
